// File: rtl/tm_pkg.sv
// Shared types and helpers for the Tsetlin Machine clause training datapath:
// feedback kinds, the feedback FSM encoding and the TA reset value.
package tm_pkg;

    localparam int DEF_STATE_BITS = 8;

    typedef enum logic [1:0] {
        FB_NONE  = 2'b00,
        FB_TYPE1 = 2'b01,
        FB_TYPE2 = 2'b10
    } fb_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        UPDATE = 2'b01,
        DONE   = 2'b10
    } fsm_e;

    // Largest "exclude" value: one step below the include boundary.
    function automatic logic [31:0] ta_reset_value(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/tm_ta_update.sv
// Combinational next-state of a single Tsetlin Automaton under Type I / Type II
// feedback, saturating at both ends of the counter range.
module tm_ta_update
    import tm_pkg::*;
#(
    parameter int STATE_BITS = DEF_STATE_BITS
) (
    input  logic [STATE_BITS-1:0] state,
    input  logic                  literal,
    input  logic                  clause,
    input  logic [1:0]            fb_type,
    input  logic [15:0]           r,
    input  logic [15:0]           s_thresh,
    output logic [STATE_BITS-1:0] next_state
);

    localparam logic [STATE_BITS-1:0] STATE_MAX = '1;

    logic rand_hit;
    logic inc;
    logic dec;

    always_comb begin
        rand_hit = (r < s_thresh);
        inc      = 1'b0;
        dec      = 1'b0;
        case (fb_type)
            FB_TYPE1: begin
                // Reinforce a true literal of a firing clause with prob (s-1)/s,
                // otherwise forget with prob 1/s.
                if (clause && literal) inc = !rand_hit;
                else                   dec = rand_hit;
            end
            FB_TYPE2: inc = clause && !literal && !state[STATE_BITS-1];
            default: ;
        endcase

        next_state = state;
        if (inc && (state != STATE_MAX))
            next_state = state + 1'b1;
        else if (dec && (state != '0))
            next_state = state - 1'b1;
    end

endmodule

// File: rtl/tm_clause_feedback.sv
// TA state bank of one clause; applies one feedback pass LANES literals per cycle
// and publishes the per-literal exclude vector for the clause evaluator.
module tm_clause_feedback
    import tm_pkg::*;
#(
    parameter int          N_FEATURES = 784,
    parameter int          LANES      = 16,
    parameter int          STATE_BITS = DEF_STATE_BITS,
    parameter logic [15:0] S_THRESH   = 16'd16807
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              fb_type,
    input  logic                    clause_i,
    input  logic [N_FEATURES-1:0]   features,
    input  logic [16*LANES-1:0]     rand_i,
    output logic                    busy,
    output logic                    done,
    output logic [2*N_FEATURES-1:0] exclude_state,
    output logic [1:0]              state_dbg
);

    localparam int N_LIT  = 2 * N_FEATURES;
    localparam int CHUNKS = N_LIT / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int KW     = $clog2(N_LIT);

    localparam logic [STATE_BITS-1:0] TA_RESET   = STATE_BITS'(ta_reset_value(STATE_BITS));
    localparam logic [CW-1:0]         LAST_CHUNK = CW'(CHUNKS - 1);

    fsm_e                  fsm;
    logic [CW-1:0]         chunk;
    logic [1:0]            fb_q;
    logic                  clause_q;
    logic [N_FEATURES-1:0] feat_q;
    logic [STATE_BITS-1:0] ta_state [N_LIT];

    logic [N_LIT-1:0]      literals;
    logic [KW-1:0]         base;
    logic [LANES-1:0]      lane_lit;
    logic [STATE_BITS-1:0] lane_cur [LANES];
    logic [STATE_BITS-1:0] lane_nxt [LANES];

    // Literal k for k >= N is feature k-N; below N it is the negated feature k.
    assign literals = {feat_q, ~feat_q};

    always_comb begin
        base     = KW'(chunk) * KW'(LANES);
        lane_lit = literals[base +: LANES];
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_cur[j] = ta_state[base + KW'(j)];

        tm_ta_update #(
            .STATE_BITS(STATE_BITS)
        ) u_ta_update (
            .state     (lane_cur[j]),
            .literal   (lane_lit[j]),
            .clause    (clause_q),
            .fb_type   (fb_q),
            .r         (rand_i[16*j +: 16]),
            .s_thresh  (S_THRESH),
            .next_state(lane_nxt[j])
        );
    end

    // Handshake: start is taken only in IDLE (busy=0, done=0); while busy=1 or
    // done=1 it is dropped, never queued. done pulses once per accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            chunk    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fb_q     <= FB_NONE;
            clause_q <= 1'b0;
            feat_q   <= '0;
            for (int k = 0; k < N_LIT; k++) ta_state[k] <= TA_RESET;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        if ((fb_type == FB_TYPE1) || (fb_type == FB_TYPE2)) begin
                            fb_q     <= fb_type;
                            clause_q <= clause_i;
                            feat_q   <= features;
                            chunk    <= '0;
                            busy     <= 1'b1;
                            fsm      <= UPDATE;
                        end else begin
                            done <= 1'b1;
                            fsm  <= DONE;
                        end
                    end
                end
                UPDATE: begin
                    for (int j = 0; j < LANES; j++)
                        ta_state[base + KW'(j)] <= lane_nxt[j];
                    if (chunk == LAST_CHUNK) begin
                        chunk <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fsm   <= DONE;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                DONE:    fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < N_LIT; k++)
            exclude_state[k] = ~ta_state[k][STATE_BITS-1];
    end

    assign state_dbg = fsm;

endmodule

// File: tb/tb_tm_clause_feedback.sv
// Randomized scoreboard bench for tm_clause_feedback: a literal-level reference
// model predicts the exclude vector and busy length of every pass.
module tb_tm_clause_feedback;
    import tm_pkg::*;

    localparam int          NF    = 784;
    localparam int          LANES = 16;
    localparam int          SB    = 8;
    localparam int          NL    = 2 * NF;
    localparam int          C     = NL / LANES;
    localparam logic [15:0] THR   = 16'd16807;
    localparam int          INC_B = 1 << (SB - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        fb_type = 2'b00;
    logic              clause_i = 1'b0;
    logic [NF-1:0]     features = '0;
    logic [16*LANES-1:0] rand_i = '0;
    logic              busy;
    logic              done;
    logic [NL-1:0]     exclude_state;
    logic [1:0]        state_dbg;

    tm_clause_feedback #(
        .N_FEATURES(NF),
        .LANES     (LANES),
        .STATE_BITS(SB),
        .S_THRESH  (THR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fb_type      (fb_type),
        .clause_i     (clause_i),
        .features     (features),
        .rand_i       (rand_i),
        .busy         (busy),
        .done         (done),
        .exclude_state(exclude_state),
        .state_dbg    (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state and reference model
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [NL-1:0] exp_q[$];
    int            exp_len_q[$];
    int            mstate[NL];
    logic [15:0]   rtab[C][LANES];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [NL-1:0] act, input logic [NL-1:0] exp);
        int first;
        int ndiff;
        first = -1;
        ndiff = 0;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < NL; k++) begin
                if (act[k] !== exp[k]) begin
                    ndiff++;
                    if (first < 0) first = k;
                end
            end
            $display("FAIL %s: %0d bits differ, first at bit %0d (actual %b required %b)",
                     name, ndiff, first, act[first], exp[first]);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NL; k++) mstate[k] = INC_B - 1;
    endfunction

    // One pass, literal by literal, straight from the feedback rules.
    function automatic void model_pass(input logic [1:0] fb, input logic cl, input logic [NF-1:0] f);
        logic lit;
        logic hit;
        for (int k = 0; k < NL; k++) begin
            lit = (k >= NF) ? f[k-NF] : !f[k];
            hit = rtab[k / LANES][k % LANES] < THR;
            if (fb == 2'b01) begin
                if (cl && lit) begin
                    if (!hit) mstate[k] = mstate[k] + 1;
                end else if (hit) begin
                    mstate[k] = mstate[k] - 1;
                end
            end else if (fb == 2'b10) begin
                if (cl && !lit && mstate[k] < INC_B) mstate[k] = mstate[k] + 1;
            end
            if (mstate[k] < 0) mstate[k] = 0;
            if (mstate[k] > (1 << SB) - 1) mstate[k] = (1 << SB) - 1;
        end
    endfunction

    function automatic logic [NL-1:0] model_excl();
        logic [NL-1:0] v;
        for (int k = 0; k < NL; k++) v[k] = (mstate[k] < INC_B);
        return v;
    endfunction

    function automatic logic [16*LANES-1:0] pack(input int c);
        logic [16*LANES-1:0] v;
        for (int j = 0; j < LANES; j++) v[16*j +: 16] = rtab[c][j];
        return v;
    endfunction

    function automatic logic [NF-1:0] rand_feat();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    // rmode 0: all zero, 1: all 16'hFFFF, 2: random with threshold corners
    function automatic void fill_rand(input int rmode);
        for (int c = 0; c < C; c++) begin
            for (int j = 0; j < LANES; j++) begin
                if (rmode == 0)      rtab[c][j] = 16'h0000;
                else if (rmode == 1) rtab[c][j] = 16'hFFFF;
                else begin
                    case ($urandom_range(0, 5))
                        0:       rtab[c][j] = THR - 16'd1;
                        1:       rtab[c][j] = THR;
                        2:       rtab[c][j] = 16'($urandom_range(0, 32'(THR) - 1));
                        default: rtab[c][j] = 16'($urandom_range(0, 65535));
                    endcase
                end
            end
        end
    endfunction

    // Monitor: pops one expectation per done pulse
    task automatic monitor();
        int            run;
        logic [NL-1:0] e;
        int            l;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: actual done=1 required 0 (no pass pending)");
                end else begin
                    e = exp_q.pop_front();
                    l = exp_len_q.pop_front();
                    check_vec("pass_excl", exclude_state, e);
                    check_val("busy_len", run, l);
                    check_val("busy_at_done", 32'(busy), 0);
                end
                run = 0;
            end else if (busy) begin
                run++;
            end
        end
    endtask

    // Driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: actual busy=%0b done=%0b required idle within 400 cycles", busy, done);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic run_pass(input logic [1:0] fb, input logic cl, input logic [NF-1:0] f,
                            input int rmode, input int poke_at, input int abort_at);
        logic is_pass;
        is_pass = (fb == 2'b01) || (fb == 2'b10);
        fill_rand(rmode);
        wait_idle();
        if (abort_at < 0) begin
            if (is_pass) model_pass(fb, cl, f);
            exp_q.push_back(model_excl());
            exp_len_q.push_back(is_pass ? C : 0);
        end
        start    = 1'b1;
        fb_type  = fb;
        clause_i = cl;
        features = f;
        rand_i   = pack(0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        fb_type  = 2'($urandom_range(0, 3));
        clause_i = 1'($urandom);
        features = ~f;
        if (!is_pass) begin
            @(negedge clk);
            check_val("noop_done", 32'(done), 1);
            check_val("noop_busy", 32'(busy), 0);
            return;
        end
        for (int c = 0; c < C; c++) begin
            @(negedge clk);
            rand_i = pack(c);
            start  = (c == poke_at);
            if (c == poke_at) begin
                fb_type  = 2'b01;
                clause_i = ~cl;
            end
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check_vec("abort_excl", exclude_state, '1);
                check_val("abort_busy", 32'(busy), 0);
                check_val("abort_state", 32'(state_dbg), 32'(IDLE));
                @(negedge clk);
                check_val("abort_no_done", 32'(done), 0);
                #2 rst = 1'b0;
                start = 1'b0;
                model_reset();
                return;
            end
        end
        // Start held into the DONE cycle must also be dropped.
        @(negedge clk);
        start = 1'b0;
    endtask

    // Main sequence
    initial begin
        logic [NL-1:0] e;
        logic [NF-1:0] f;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_vec("reset_excl", exclude_state, '1);
        check_val("reset_busy", 32'(busy), 0);
        check_val("reset_done", 32'(done), 0);
        check_val("reset_state", 32'(state_dbg), 32'(IDLE));

        // No-op feedback types
        run_pass(2'b00, 1'b1, rand_feat(), 2, -1, -1);
        run_pass(2'b11, 1'b1, rand_feat(), 2, -1, -1);

        // Type I full include
        run_pass(2'b01, 1'b1, '1, 1, -1, -1);
        wait_idle();
        check_vec("t1_include", exclude_state, {{NF{1'b0}}, {NF{1'b1}}});

        // Type II from reset, only feature 0 set
        do_reset();
        f = '0;
        f[0] = 1'b1;
        run_pass(2'b10, 1'b1, f, 2, -1, -1);
        wait_idle();
        e = '1;
        e[NL-1:NF+1] = '0;
        e[0] = 1'b0;
        check_vec("t2_pass", exclude_state, e);

        // Random passes, some with start poked while busy / into DONE
        for (int i = 0; i < 12; i++) begin
            int poke;
            poke = (i == 3) ? C - 1 : (($urandom_range(0, 2) == 0) ? int'($urandom_range(0, C - 1)) : -1);
            run_pass(2'($urandom_range(0, 3)), 1'($urandom), rand_feat(), 2, poke, -1);
        end

        // Abort mid-pass, then a fresh pass must still be accepted
        run_pass(2'b01, 1'b1, rand_feat(), 2, -1, 40);
        run_pass(2'b01, 1'b1, rand_feat(), 2, -1, -1);
        run_pass(2'b10, 1'b1, rand_feat(), 2, -1, -1);

        // Saturation at zero
        do_reset();
        for (int i = 0; i < 130; i++)
            run_pass(2'b01, 1'b0, rand_feat(), 0, -1, -1);
        wait_idle();
        check_vec("sat_excl", exclude_state, '1);

        repeat (3) @(negedge clk);
        check_val("pending_exp", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
